packet_serializer: RTL and testbench

Transmit-side stage directly downstream of the packet builder. It accepts one finished 288-bit packet (9 x 32-bit words: 4 header, 1 checksum, 4 data) on a one-cycle valid pulse and shifts it out bit-serially to the laser driver. Each frame is a preamble, a start-of-frame delimiter and the payload sent MSB first, followed by a fixed inter-frame gap. Packets offered while a frame is in flight are dropped and counted.

---
 rtl/packet_serializer.sv | 176 +++++++++++++++++
 tb/tb_packet_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_serializer.sv
// packet_serializer: latches one 288-bit packet and shifts it onto the serial
// line as preamble, start-of-frame delimiter and MSB-first payload. Each frame
// is followed by a fixed idle gap. Packets offered while busy are dropped and
// counted with a saturating counter.
module packet_serializer #(
  parameter int unsigned CLKS_PER_BIT  = 16,
  parameter int unsigned GAP_BITS      = 8,
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [7:0]  SFD           = 8'hD5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [287:0] packet,
  input  logic         packet_valid,
  output logic         ready,
  output logic         tx_en,
  output logic         tx_bit,
  output logic         done,
  output logic [7:0]   drop_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [15:0] TMR_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [8:0]  PRE_LAST = 9'(PREAMBLE_BITS - 1);
  localparam logic [8:0]  SFD_LAST = 9'd7;
  localparam logic [8:0]  PAY_LAST = 9'd287;
  localparam logic [8:0]  GAP_LAST = 9'(GAP_BITS - 1);

  logic [2:0]   r_state;
  logic [15:0]  r_tmr;
  logic [8:0]   r_idx;
  logic [287:0] r_sh;
  logic         r_tx_en;
  logic         r_tx_bit;
  logic         r_done;
  logic [7:0]   r_drop;

  logic         w_ready;
  logic         w_accept;
  logic         w_busy;
  logic         w_bit_end;
  logic [8:0]   w_last_idx;
  logic         w_state_done;
  logic [2:0]   w_sfd_sel;

  assign w_ready      = (r_state == S_IDLE);
  assign w_accept     = packet_valid & w_ready;
  assign w_busy       = ~w_ready;
  // Timer wrap marks the last cycle of the current bit period.
  assign w_bit_end    = w_busy & (r_tmr == TMR_LAST);
  assign w_state_done = w_bit_end & (r_idx == w_last_idx);
  // SFD bit that follows the one currently on the line (idx 0 shows bit 7).
  assign w_sfd_sel    = 3'd6 - r_idx[2:0];

  // Index of the final bit period of each state.
  always_comb begin
    w_last_idx = 9'd0;
    case (r_state)
      S_PRE:   w_last_idx = PRE_LAST;
      S_SFD:   w_last_idx = SFD_LAST;
      S_PAY:   w_last_idx = PAY_LAST;
      S_GAP:   w_last_idx = GAP_LAST;
      default: w_last_idx = 9'd0;
    endcase
  end

  // Bit-period timer; parked at 0 when idle, so a new frame starts aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmr <= 16'd0;
    end else if (!w_busy || w_bit_end) begin
      r_tmr <= 16'd0;
    end else begin
      r_tmr <= r_tmr + 16'd1;
    end
  end

  // Frame sequencer: state and per-state bit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= 9'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_PRE;
            r_idx   <= 9'd0;
          end
        end
        S_PRE, S_SFD, S_PAY, S_GAP: begin
          if (w_state_done) begin
            r_idx <= 9'd0;
            case (r_state)
              S_PRE:   r_state <= S_SFD;
              S_SFD:   r_state <= S_PAY;
              S_PAY:   r_state <= S_GAP;
              default: r_state <= S_IDLE;
            endcase
          end else if (w_bit_end) begin
            r_idx <= r_idx + 9'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= 9'd0;
        end
      endcase
    end
  end

  // Packet shift register: loaded on accept, shifted once per payload bit so
  // bit 286 is always the next payload bit to present.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh <= '0;
    end else if (w_accept) begin
      r_sh <= packet;
    end else if (r_state == S_PAY && w_bit_end && !w_state_done) begin
      r_sh <= {r_sh[286:0], 1'b0};
    end
  end

  // Serial line: the next bit is registered at each bit-period boundary so
  // tx_bit only moves on boundaries and is 0 outside the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_bit <= 1'b0;
    end else if (w_accept) begin
      r_tx_bit <= 1'b1;
    end else if (w_bit_end) begin
      case (r_state)
        S_PRE:   r_tx_bit <= w_state_done ? SFD[7]     : ~r_tx_bit;
        S_SFD:   r_tx_bit <= w_state_done ? r_sh[287]  : SFD[w_sfd_sel];
        S_PAY:   r_tx_bit <= w_state_done ? 1'b0       : r_sh[286];
        default: r_tx_bit <= 1'b0;
      endcase
    end
  end

  // Frame enable and end-of-frame pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_en <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_PAY) & w_state_done;
      if (w_accept) begin
        r_tx_en <= 1'b1;
      end else if (r_state == S_PAY && w_state_done) begin
        r_tx_en <= 1'b0;
      end
    end
  end

  // Saturating drop counter: one count per busy cycle with a packet offered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop <= 8'd0;
    end else if (packet_valid && !w_ready && r_drop != 8'hFF) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign ready      = w_ready;
  assign tx_en      = r_tx_en;
  assign tx_bit     = r_tx_bit;
  assign done       = r_done;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_packet_serializer.sv
// Bench for packet_serializer: two instances (4 and 1 clocks per bit), a
// table of frame vectors plus random frames checked against a frame-level
// reference model, and hand-written reset and back-to-back sequences.
module tb_packet_serializer;

  localparam int GB = 4;

  logic         clk;
  logic         rn  [2];
  logic         pv  [2];
  logic [287:0] pkt [2];
  logic         rdy0, en0, b0, d0, rdy1, en1, b1, d1;
  logic [7:0]   dc0, dc1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_dc [2];

  typedef struct {
    int           sel;
    logic [287:0] pkt;
    int           drop_at;
    int           exp_dc;
  } vec_t;
  vec_t tbl[$];

  packet_serializer #(.CLKS_PER_BIT(4), .GAP_BITS(GB), .PREAMBLE_BITS(16), .SFD(8'hD5)) u_dut0 (
    .clk(clk), .reset_n(rn[0]), .packet(pkt[0]), .packet_valid(pv[0]),
    .ready(rdy0), .tx_en(en0), .tx_bit(b0), .done(d0), .drop_count(dc0));

  packet_serializer #(.CLKS_PER_BIT(1), .GAP_BITS(GB), .PREAMBLE_BITS(16), .SFD(8'hD5)) u_dut1 (
    .clk(clk), .reset_n(rn[1]), .packet(pkt[1]), .packet_valid(pv[1]),
    .ready(rdy1), .tx_en(en1), .tx_bit(b1), .done(d1), .drop_count(dc1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic smp(input int s, output logic e, output logic b, output logic d,
                     output logic r, output logic [7:0] c);
    if (s == 0) begin e = en0; b = b0; d = d0; r = rdy0; c = dc0; end
    else        begin e = en1; b = b1; d = d1; r = rdy1; c = dc1; end
  endtask

  task automatic chk_reset(input int s, input string nm);
    logic e, b, d, r;
    logic [7:0] c;
    smp(s, e, b, d, r, c);
    chk({nm, " ready"}, r, 1);
    chk({nm, " tx_en"}, e, 0);
    chk({nm, " tx_bit"}, b, 0);
    chk({nm, " done"}, d, 0);
    chk({nm, " drop_count"}, c, 0);
  endtask

  // Reference frame: 16 alternating bits starting with 1, SFD, then packet.
  function automatic logic [311:0] frame_bits(input logic [287:0] p);
    return {16'hAAAA, 8'hD5, p};
  endfunction

  function automatic int cpb_of(input int s);
    return (s == 0) ? 4 : 1;
  endfunction

  // Offer p, optionally pulse packet_valid at busy cycle drop_at, and check the
  // whole frame cycle by cycle against the reference model.
  task automatic run_frame(input int s, input logic [287:0] p, input int drop_at,
                           input int exp_d, input string nm);
    int cpb, f, g, n, bad, en_cnt, done_cnt, done_at, rdy_at;
    logic e, b, d, r, exp_e, exp_b;
    logic [7:0] c;
    logic [311:0] fr, got;
    cpb = cpb_of(s);
    f = 312 * cpb;
    g = GB * cpb;
    n = f + g + 3;
    fr = frame_bits(p);
    got = '0;
    bad = 0; en_cnt = 0; done_cnt = 0; done_at = -1; rdy_at = -1;
    @(negedge clk);
    smp(s, e, b, d, r, c);
    chk({nm, " ready before"}, r, 1);
    pkt[s] = p;
    pv[s]  = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      smp(s, e, b, d, r, c);
      pv[s]  = (k == drop_at);
      pkt[s] = {9{$urandom()}};
      if (e) en_cnt++;
      if (d) begin done_cnt++; done_at = k; end
      if (r && rdy_at < 0) rdy_at = k;
      exp_e = (k <= f);
      exp_b = exp_e ? fr[311 - (k - 1) / cpb] : 1'b0;
      if (e !== exp_e || b !== exp_b) bad++;
      if (exp_e && ((k - 1) % cpb) == cpb / 2) got[311 - (k - 1) / cpb] = b;
    end
    pv[s] = 1'b0;
    @(negedge clk);
    smp(s, e, b, d, r, c);
    chk({nm, " line cycle errors"}, bad, 0);
    n_tests++;
    if (got !== fr) begin
      n_fail++;
      $display("FAIL %s midbit stream: got %h expected %h", nm, got, fr);
    end
    chk({nm, " tx_en cycles"}, en_cnt, f);
    chk({nm, " done pulses"}, done_cnt, 1);
    chk({nm, " done cycle"}, done_at, f + 1);
    chk({nm, " ready return cycle"}, rdy_at, f + g + 1);
    chk({nm, " drop_count"}, c, exp_d);
  endtask

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [287:0] sp, pr;
    logic e, b, d, r, e2, b2;
    logic [7:0] c, prev;
    int s, f, g, drop, dec, rdy_at, gap_bad, rst_bad;

    sp = {32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h00010040, 32'hBEEF0000,
          32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    for (int i = 0; i < 2; i++) begin
      rn[i] = 1'b0; pv[i] = 1'b0; pkt[i] = '0;
    end
    #2;
    chk_reset(0, "por0");
    chk_reset(1, "por1");
    repeat (3) @(negedge clk);
    rn[0] = 1'b1;
    rn[1] = 1'b1;

    // Table: instance, packet, drop pulse cycle (-1 none), drop_count after.
    tbl.push_back('{0, sp, -1,  0});
    tbl.push_back('{0, sp, 100, 1});
    tbl.push_back('{1, sp, -1,  0});
    tbl.push_back('{1, sp, 316, 1});  // pulse in the last gap cycle is dropped
    foreach (tbl[i]) begin
      run_frame(tbl[i].sel, tbl[i].pkt, tbl[i].drop_at, tbl[i].exp_dc, $sformatf("vec%0d", i));
    end
    exp_dc[0] = 1;
    exp_dc[1] = 1;

    // Random packets and random drop pulses.
    for (int i = 0; i < 5; i++) begin
      s  = i % 2;
      pr = {9{$urandom()}};
      f  = 312 * cpb_of(s);
      g  = GB * cpb_of(s);
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, f + g)) : -1;
      if (drop > 0 && exp_dc[s] < 255) exp_dc[s]++;
      run_frame(s, pr, drop, exp_dc[s], $sformatf("rand%0d", i));
    end

    // Asynchronous reset while idle, checked before any clock edge.
    @(negedge clk);
    #2;
    rn[0] = 1'b0;
    rn[1] = 1'b0;
    #1;
    chk_reset(0, "async rst0");
    chk_reset(1, "async rst1");
    @(negedge clk);
    rn[0] = 1'b1;
    rn[1] = 1'b1;

    // Back-to-back: packet_valid held high across a frame and its gap.
    f = 1248; g = 16; dec = 0; prev = 0; rdy_at = -1; gap_bad = 0; e2 = 0; b2 = 0;
    @(negedge clk);
    pkt[0] = sp;
    pv[0]  = 1'b1;
    for (int k = 1; k <= f + g + 3; k++) begin
      @(negedge clk);
      smp(0, e, b, d, r, c);
      if (c < prev) dec++;
      prev = c;
      if (k == 101) chk("b2b drop_count at cycle 101", c, 100);
      if (r && rdy_at < 0) rdy_at = k;
      if (k > f && k <= f + g + 1 && e) gap_bad++;
      if (k == f + g + 2) begin e2 = e; b2 = b; end
    end
    pv[0] = 1'b0;
    chk("b2b drop_count saturated", c, 255);
    chk("b2b drop_count decreases", dec, 0);
    chk("b2b ready return cycle", rdy_at, f + g + 1);
    chk("b2b gap tx_en cycles", gap_bad, 0);
    chk("b2b second frame tx_en", e2, 1);
    chk("b2b second frame tx_bit", b2, 1);
    @(negedge clk);
    rn[0] = 1'b0;
    @(negedge clk);
    rn[0] = 1'b1;

    // Reset during payload bit 100, then a fresh packet.
    pr = {9{$urandom()}};
    @(negedge clk);
    pkt[0] = pr;
    pv[0]  = 1'b1;
    @(negedge clk);
    pv[0]  = 1'b0;
    repeat (496) @(negedge clk);
    smp(0, e, b, d, r, c);
    chk("midpay tx_en before reset", e, 1);
    rst_bad = 0;
    rn[0] = 1'b0;
    #1;
    smp(0, e, b, d, r, c);
    if (e !== 1'b0 || b !== 1'b0 || r !== 1'b1) rst_bad++;
    repeat (3) begin
      @(negedge clk);
      smp(0, e, b, d, r, c);
      if (e !== 1'b0 || b !== 1'b0 || r !== 1'b1) rst_bad++;
    end
    rn[0] = 1'b1;
    chk("midpay line idle in reset", rst_bad, 0);
    run_frame(0, ~pr, -1, 0, "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
